// File: rtl/async_hs_pkg.sv
// async_hs_pkg: shared types and defaults for the async output handshake.
//   hs_state_t       - handshake FSM state (IDLE, REQ_HI, REQ_LO), 2-bit.
//   SYNC_STAGES_MIN  - fewest flops allowed on the ack synchronizer.
//   CNT_W_DEF        - default pending-counter width.
//   TIMEOUT_CYC_DEF  - default per-phase timeout (ASYNC_OUT_TIMEOUT_EN only).
package async_hs_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ_HI = 2'b01,
    REQ_LO = 2'b10
  } hs_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int CNT_W_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 255;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: N-stage flop synchronizer for a single asynchronous bit.
//   clk   in  sampling clock
//   rst_n in  async active-low reset, chain clears to 0
//   d     in  asynchronous input
//   q     out synchronized output (last stage)
// STAGES below the package minimum is raised to the minimum.
module sync_2ff
  import async_hs_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  localparam int STG = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [STG-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STG-2:0], d};
  end

  assign q = sr[STG-1];
endmodule

// File: rtl/async_output_handshake.sv
// async_output_handshake: sends single-cycle clk-domain events to an
// asynchronous peer over a 4-phase req/ack handshake.
//   clk         in  system clock
//   rst_n       in  async active-low reset
//   event_in    in  single-cycle event request (held N cycles = N events)
//   ack_in      in  peer acknowledge, unsynchronized
//   req_out     out request to peer, straight from a flop
//   busy        out state != IDLE
//   done        out one-cycle pulse on handshake completion
//   pending     out events queued, not yet launched (saturates at 2^CNT_W-1)
//   overflow    out one-cycle pulse when an event is dropped
//   timeout_err out sticky phase-timeout flag
// Build option: ASYNC_OUT_TIMEOUT_EN adds a per-phase timeout of TIMEOUT_CYC
// cycles; without it the FSM waits forever and timeout_err is tied 0.
module async_output_handshake
  import async_hs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             event_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hs_state_t state;
  logic      ack_s;
  logic      pend_nz, launch, ev_take, pend_dec;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ack_in),
    .q    (ack_s)
  );

  // ack_s high in IDLE blocks launch: the peer has not released the last
  // (or a pre-reset) handshake yet.
  assign pend_nz  = (pending != '0);
  assign launch   = (state == IDLE) && !ack_s && (pend_nz || event_in);
  // Launching from an empty queue uses event_in directly.
  assign ev_take  = event_in && !(launch && !pend_nz);
  assign pend_dec = launch && pend_nz;

`ifdef ASYNC_OUT_TIMEOUT_EN
  localparam int             PH_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TIMEOUT_CYC - 1);

  logic [PH_W-1:0] phase;
  logic            ph_exp, hs_leave, aborted, to_err_q;

  assign ph_exp   = (phase == PH_LAST);
  assign hs_leave = ((state == REQ_HI) && (ack_s || ph_exp)) ||
                    ((state == REQ_LO) && (!ack_s || ph_exp));
  assign timeout_err = to_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      pending  <= '0;
`ifdef ASYNC_OUT_TIMEOUT_EN
      phase    <= '0;
      aborted  <= 1'b0;
      to_err_q <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      overflow <= 1'b0;

      // Simultaneous enqueue and dequeue cancel out (also at saturation).
      if (ev_take && !pend_dec) begin
        if (pending == CNT_MAX) overflow <= 1'b1;
        else                    pending  <= pending + CNT_ONE;
      end else if (pend_dec && !ev_take) begin
        pending <= pending - CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (launch) begin
            state   <= REQ_HI;
            req_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            state   <= REQ_LO;
            req_out <= 1'b0;
          end
`ifdef ASYNC_OUT_TIMEOUT_EN
          else if (ph_exp) begin
            state    <= REQ_LO;
            req_out  <= 1'b0;
            to_err_q <= 1'b1;
            aborted  <= 1'b1;
          end
`endif
        end
        REQ_LO: begin
          if (!ack_s) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef ASYNC_OUT_TIMEOUT_EN
            // A handshake that already timed out does not count as done.
            done    <= !aborted;
            aborted <= 1'b0;
`else
            done  <= 1'b1;
`endif
          end
`ifdef ASYNC_OUT_TIMEOUT_EN
          else if (ph_exp) begin
            state    <= IDLE;
            busy     <= 1'b0;
            to_err_q <= 1'b1;
            aborted  <= 1'b0;
          end
`endif
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase

`ifdef ASYNC_OUT_TIMEOUT_EN
      if (state == IDLE || hs_leave) phase <= '0;
      else                           phase <= phase + PH_W'(1);
`endif
    end
  end
endmodule

// File: tb/tb_async_output_handshake.sv
module tb_async_output_handshake;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // main DUT: peer either auto (ack = req delayed 3 ns) or manual
  logic       ev = 1'b0, ack_man = 1'b0, peer_auto = 1'b1;
  logic       ack_dly, ack;
  logic       req, busy, done, ovf, terr;
  logic [3:0] pend;
  assign #3 ack_dly = req;
  assign ack = peer_auto ? ack_dly : ack_man;

  async_output_handshake u_dut (
    .clk(clk), .rst_n(rst_n), .event_in(ev), .ack_in(ack),
    .req_out(req), .busy(busy), .done(done), .pending(pend),
    .overflow(ovf), .timeout_err(terr)
  );

  // overflow DUT: CNT_W=2, ack stuck low
  logic       ev_ov = 1'b0, ack_ov = 1'b0;
  logic       req_ov, busy_ov, done_ov, ovf_ov, terr_ov;
  logic [1:0] pend_ov;
  async_output_handshake #(.CNT_W(2)) u_ov (
    .clk(clk), .rst_n(rst_n), .event_in(ev_ov), .ack_in(ack_ov),
    .req_out(req_ov), .busy(busy_ov), .done(done_ov), .pending(pend_ov),
    .overflow(ovf_ov), .timeout_err(terr_ov)
  );

  // timeout DUT: TIMEOUT_CYC=8, peer never acks
  logic       ev_to = 1'b0, ack_to = 1'b0;
  logic       req_to, busy_to, done_to, ovf_to, terr_to;
  logic [3:0] pend_to;
  async_output_handshake #(.TIMEOUT_CYC(8)) u_to (
    .clk(clk), .rst_n(rst_n), .event_in(ev_to), .ack_in(ack_to),
    .req_out(req_to), .busy(busy_to), .done(done_to), .pending(pend_to),
    .overflow(ovf_to), .timeout_err(terr_to)
  );

  int req_toggles = 0;
  always @(req) req_toggles++;

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({req, busy, done, ovf, terr, pend} !== 9'd0) begin
      n_bad++; $display("FAIL reset_main: got %b want 0", {req, busy, done, ovf, terr, pend});
    end
    n_cmp++;
    if ({req_ov, busy_ov, done_ov, ovf_ov, terr_ov, pend_ov} !== 7'd0) begin
      n_bad++; $display("FAIL reset_ov: got %b want 0", {req_ov, busy_ov, done_ov, ovf_ov, terr_ov, pend_ov});
    end
    n_cmp++;
    if ({req_to, busy_to, done_to, ovf_to, terr_to, pend_to} !== 9'd0) begin
      n_bad++; $display("FAIL reset_to: got %b want 0", {req_to, busy_to, done_to, ovf_to, terr_to, pend_to});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_single();
    int rise = -1, fall = -1, dn = -1, dn_cnt = 0;
    bit pend_bad = 0;
    peer_auto = 1'b1;
    @(negedge clk);
    ev = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) ev = 1'b0;
      if (req && rise < 0) rise = i;
      if (!req && rise >= 0 && fall < 0) fall = i;
      if (done) begin dn_cnt++; if (dn < 0) dn = i; end
      if (pend !== 4'd0) pend_bad = 1;
    end
    n_cmp++;
    if (rise !== 1) begin n_bad++; $display("FAIL single_req_rise: got %0d want 1", rise); end
    n_cmp++;
    if (fall !== 4) begin n_bad++; $display("FAIL single_req_fall: got %0d want 4", fall); end
    n_cmp++;
    if (dn !== 7) begin n_bad++; $display("FAIL single_done_at: got %0d want 7", dn); end
    n_cmp++;
    if (dn_cnt !== 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", dn_cnt); end
    n_cmp++;
    if (pend_bad) begin n_bad++; $display("FAIL single_pending: got nonzero want 0"); end
  endtask

  task automatic test_back_to_back();
    int dn_at[8];
    int dn_cnt = 0, maxp = 0;
    bit gap_bad = 0;
    peer_auto = 1'b1;
    @(negedge clk);
    ev = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 5) ev = 1'b0;
      if (int'(pend) > maxp) maxp = int'(pend);
      if (done && dn_cnt < 8) begin dn_at[dn_cnt] = i; dn_cnt++; end
    end
    for (int k = 1; k < dn_cnt && k < 5; k++)
      if (dn_at[k] - dn_at[k-1] != 7) gap_bad = 1;
    n_cmp++;
    if (maxp !== 4) begin n_bad++; $display("FAIL burst_max_pending: got %0d want 4", maxp); end
    n_cmp++;
    if (dn_cnt !== 5) begin n_bad++; $display("FAIL burst_done_cnt: got %0d want 5", dn_cnt); end
    n_cmp++;
    if (dn_cnt < 1 || dn_at[0] !== 7) begin n_bad++; $display("FAIL burst_first_done: got %0d want 7", dn_cnt < 1 ? -1 : dn_at[0]); end
    n_cmp++;
    if (gap_bad) begin n_bad++; $display("FAIL burst_done_gap: got irregular want 7"); end
    n_cmp++;
    if ({pend, busy} !== 5'd0) begin n_bad++; $display("FAIL burst_drain: got pend=%0d busy=%b want 0/0", pend, busy); end
  endtask

  task automatic test_glitch();
    int tog0;
    bit bad = 0;
    int wait_cyc = 0;
    peer_auto = 1'b0;
    ack_man = 1'b0;
    @(negedge clk);
    ev = 1'b1;
    @(negedge clk);
    ev = 1'b0;
    n_cmp++;
    if (req !== 1'b1) begin n_bad++; $display("FAIL glitch_launch: got req=%b want 1", req); end
    tog0 = req_toggles;
    for (int i = 0; i < 4; i++) begin
      #1 ack_man = 1'b1;
      #1 ack_man = 1'b0;
      @(negedge clk);
      if (req !== 1'b1 || busy !== 1'b1) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL glitch_state: got req/busy dropped want held 1"); end
    n_cmp++;
    if (req_toggles - tog0 !== 0) begin n_bad++; $display("FAIL glitch_toggles: got %0d want 0", req_toggles - tog0); end
    peer_auto = 1'b1;
    while (!done && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL glitch_finish: got no done want done within 20"); end
    n_cmp++;
    if (req_toggles - tog0 !== 1) begin n_bad++; $display("FAIL glitch_fsm_toggles: got %0d want 1", req_toggles - tog0); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overflow();
    int ov_cnt = 0, ov_at = -1;
    @(negedge clk);
    ev_ov = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) ev_ov = 1'b0;
      if (ovf_ov) begin ov_cnt++; if (ov_at < 0) ov_at = i; end
    end
    n_cmp++;
    if (pend_ov !== 2'd3) begin n_bad++; $display("FAIL ovf_pending: got %0d want 3", pend_ov); end
    n_cmp++;
    if (ov_cnt !== 1) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 1", ov_cnt); end
    n_cmp++;
    if (ov_at !== 5) begin n_bad++; $display("FAIL ovf_at: got %0d want 5", ov_at); end
    n_cmp++;
    if ({req_ov, busy_ov, done_ov} !== 3'b110) begin n_bad++; $display("FAIL ovf_state: got %b want 110", {req_ov, busy_ov, done_ov}); end
  endtask

  task automatic test_timeout();
    int hi = 0, dn_cnt = 0, fall = -1;
    bit err_seen = 0, err_drop = 0;
    @(negedge clk);
    ev_to = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) ev_to = 1'b0;
      if (req_to) hi++;
      if (!req_to && hi > 0 && fall < 0) fall = i;
      if (done_to) dn_cnt++;
      if (terr_to) err_seen = 1;
      if (err_seen && !terr_to) err_drop = 1;
    end
`ifdef ASYNC_OUT_TIMEOUT_EN
    n_cmp++;
    if (hi !== 8) begin n_bad++; $display("FAIL to_req_high: got %0d want 8", hi); end
    n_cmp++;
    if (fall !== 9) begin n_bad++; $display("FAIL to_req_fall: got %0d want 9", fall); end
    n_cmp++;
    if (terr_to !== 1'b1 || err_drop) begin n_bad++; $display("FAIL to_err_sticky: got %b drop=%b want 1/0", terr_to, err_drop); end
    n_cmp++;
    if (dn_cnt !== 0) begin n_bad++; $display("FAIL to_no_done: got %0d want 0", dn_cnt); end
    n_cmp++;
    if (busy_to !== 1'b0) begin n_bad++; $display("FAIL to_idle: got busy=%b want 0", busy_to); end
`else
    n_cmp++;
    if (hi !== 30) begin n_bad++; $display("FAIL to_wait_forever: got %0d want 30", hi); end
    n_cmp++;
    if (err_seen) begin n_bad++; $display("FAIL to_err_tied: got 1 want 0"); end
    n_cmp++;
    if (dn_cnt !== 0) begin n_bad++; $display("FAIL to_no_done: got %0d want 0", dn_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    bit early = 0;
    int wait_cyc = 0;
    peer_auto = 1'b0;
    ack_man = 1'b0;
    @(negedge clk);
    ev = 1'b1;
    @(negedge clk);
    ev = 1'b0;
    n_cmp++;
    if ({req, busy} !== 2'b11) begin n_bad++; $display("FAIL rmid_launch: got %b want 11", {req, busy}); end
    ack_man = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req, busy, done, ovf, terr, pend} !== 9'd0) begin
      n_bad++; $display("FAIL rmid_clear: got %b want 0", {req, busy, done, ovf, terr, pend});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ev = 1'b1;
    @(negedge clk);
    ev = 1'b0;
    n_cmp++;
    if ({pend, req} !== 5'b00010) begin n_bad++; $display("FAIL rmid_queued: got pend=%0d req=%b want 1/0", pend, req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (req) early = 1;
    end
    ack_man = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      if (req) early = 1;
    end
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL rmid_blocked: got launch while ack high want none"); end
    @(negedge clk);
    n_cmp++;
    if ({req, pend} !== 5'b10000) begin n_bad++; $display("FAIL rmid_relaunch: got req=%b pend=%0d want 1/0", req, pend); end
    peer_auto = 1'b1;
    while (!done && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL rmid_done: got no done want done within 20"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_overflow();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/async_output_handshake.md
Name: async_output_handshake

Overview:
- Transmit-side counterpart of the input synchronizer: carries single-cycle events from the clk domain to an asynchronous peer over a 4-phase req/ack handshake.
- req_out is driven glitch-free, directly from a state flop. ack_in is asynchronous and is brought into the clk domain by an internal flop chain.
- A saturating pending counter buffers events that arrive while a handshake is in flight.
- Sits at the chip/board boundary, opposite the input synchronizer on the same link.

Parameters:
- SYNC_STAGES, 2: flop stages on ack_in (minimum 2).
- CNT_W, 4: width of the pending-event counter; capacity is 2^CNT_W-1 events.
- TIMEOUT_CYC, 255: cycles allowed per handshake phase; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- event_in  in  1  single-cycle event request, clk domain.
- ack_in  in  1  acknowledge from the async peer; unsynchronized.
- req_out  out  1  request to the async peer; registered.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse when a handshake completes.
- pending  out  CNT_W  events queued and not yet launched.
- overflow  out  1  one-cycle pulse when an event is dropped.
- timeout_err  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset: asserting rst_n low immediately clears every output (req_out, busy, done, overflow, timeout_err = 0; pending = 0), the state (-> IDLE) and all sync flops. This applies mid-handshake too.
- ack_s: the last flop of the SYNC_STAGES chain on ack_in. The FSM uses only ack_s, never raw ack_in.
- State IDLE (req_out=0):
  - Launch when ack_s==0 and (pending!=0 or event_in).
  - Next state REQ_HI; req_out=1 after that same edge, i.e. 1-cycle latency from event_in.
  - ack_s==1 blocks launch. This covers a peer still holding ack after a reset.
- State REQ_HI (req_out=1): ack_s==1 -> REQ_LO.
- State REQ_LO (req_out=0): ack_s==0 -> IDLE, with done=1 for exactly one cycle on entry to IDLE.
- Throughput: with a zero-delay peer, req_out is high for SYNC_STAGES+1 cycles. Event-to-event period is 2*(SYNC_STAGES+1)+1 cycles (7 at default).
- Pending counter, per edge:
  - +1 if event_in and not consumed.
  - -1 if launch consumes a queued event.
  - Launch from empty with event_in consumes event_in directly; pending stays 0.
  - Simultaneous event_in and launch from pending!=0: no change.
- Saturation: at pending==2^CNT_W-1, a non-consumed event_in is dropped and overflow=1 for that cycle.
- event_in held high N cycles counts as N events.

Optional Feature:
- Macro: ASYNC_OUT_TIMEOUT_EN.
- Defined:
  - A phase counter clears on every state change and increments in REQ_HI and REQ_LO.
  - Reaching TIMEOUT_CYC in REQ_HI forces REQ_LO (req_out drops).
  - Reaching TIMEOUT_CYC in REQ_LO forces IDLE with no done pulse.
  - Either timeout sets timeout_err, which stays high until reset.
  - The IDLE ack_s==0 launch guard still applies.
- Undefined: no phase counter; the FSM waits indefinitely; timeout_err is constant 0.

Decomposition:
- Package async_hs_pkg holds:
  - the state typedef (IDLE, REQ_HI, REQ_LO, 2-bit encoding);
  - the SYNC_STAGES minimum constant;
  - the default CNT_W and TIMEOUT_CYC constants.
- Sub-module sync_2ff: a parameterized N-stage flop synchronizer with async active-low reset, reset value 0. It is instantiated once, on ack_in.
- The FSM, pending counter and timeout logic stay in the top module.

Test Plan:
- Single event, peer with ack = req delayed 3 ns:
  - event_in pulse at cycle 10 -> req_out=1 at cycle 11, req_out=0 at cycle 14, done=1 at cycle 17, pending=0 throughout.
- Burst of 5 consecutive event_in cycles during an active handshake:
  - pending reaches 4 (first event launches directly).
  - 5 done pulses, each 7 cycles apart.
  - pending returns to 0.
- Overflow, CNT_W=2, peer ack stuck low:
  - 5 events -> 1 launched, pending=3, overflow pulses once on the 5th event.
- Reset mid-REQ_HI with peer holding ack=1:
  - req_out drops immediately and all outputs = 0.
  - After release, no launch until ack_in low for SYNC_STAGES edges, then the queued event launches.
- ASYNC_OUT_TIMEOUT_EN, TIMEOUT_CYC=8, peer never acks:
  - req_out high for 8 cycles, then low.
  - timeout_err=1 and stays set.
  - No done pulse.
- Glitchy ack_in (1 ns pulse between edges, not captured):
  - No state change.
  - req_out stays stable, with no toggles other than FSM-driven ones.
